// File: rtl/alu_cmd_issuer.sv
// Issue stage for a 4-bit 74181-style ALU: queues commands, drives the ALU, holds, samples F, returns results in order.
// Optional ALU_OP_COUNT_EN adds an 8-bit saturating count of completed result handshakes (op_count).
module alu_cmd_issuer #(
    parameter int DEPTH         = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    // Both handshakes: a transfer happens on a rising edge where valid && ready;
    // the producer holds its payload and valid until that edge.
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [3:0] cmd_s,
    input  logic       cmd_m,
    input  logic       cmd_cn,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [3:0] alu_s,
    output logic       alu_m,
    output logic       alu_cn,
    input  logic [3:0] alu_f,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [3:0] res_f
`ifdef ALU_OP_COUNT_EN
    ,
    output logic [7:0] op_count
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(SETTLE_CYCLES + 1);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       m;
        logic       cn;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [SW-1:0]  cnt;
    logic [SW-1:0]  cnt_d;

    cmd_t           mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;

    logic           push;
    logic           pop;
    logic           capture;
    logic           fifo_empty;

    // Ready looks only at the registered count, so a same-edge pop never frees a slot early.
    assign cmd_ready  = (count < CW'(DEPTH));
    assign push       = cmd_valid && cmd_ready;
    assign fifo_empty = (count == '0);
    assign res_valid  = (state == HOLD);

    // ---------------- FIFO storage and pointers ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, s: cmd_s, m: cmd_m, cn: cmd_cn};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- issue FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pop     = 1'b0;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cnt_d   = SW'(SETTLE_CYCLES);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                cnt_d = cnt - SW'(1);
                if (cnt == SW'(1)) begin
                    capture = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        cnt_d   = SW'(SETTLE_CYCLES);
                        state_d = DRIVE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ---------------- ALU drive and result capture ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a  <= '0;
            alu_b  <= '0;
            alu_s  <= '0;
            alu_m  <= 1'b0;
            alu_cn <= 1'b0;
            res_f  <= '0;
        end else begin
            if (pop) begin
                alu_a  <= mem[rd_ptr].a;
                alu_b  <= mem[rd_ptr].b;
                alu_s  <= mem[rd_ptr].s;
                alu_m  <= mem[rd_ptr].m;
                alu_cn <= mem[rd_ptr].cn;
            end
            if (capture) begin
                res_f <= alu_f;
            end
        end
    end

`ifdef ALU_OP_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count <= '0;
        end else if (res_valid && res_ready && (op_count != 8'hff)) begin
            op_count <= op_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed bench for alu_cmd_issuer (DEPTH=4, SETTLE_CYCLES=1) with a behavioural ALU on alu_f.
// Define ALU_OP_COUNT_EN at compile time to also exercise op_count.
module tb_alu_cmd_issuer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [3:0] cmd_s;
    logic       cmd_m;
    logic       cmd_cn;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_s;
    logic       alu_m;
    logic       alu_cn;
    logic [3:0] alu_f;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_f;
`ifdef ALU_OP_COUNT_EN
    logic [7:0] op_count;
`endif

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] s;
        logic       m;
        logic       cn;
        logic [3:0] exp;
    } vec_t;

    vec_t       vecs [7];
    logic [3:0] exp_q [$];
    int         n_checks;
    int         n_errors;

    alu_cmd_issuer #(.DEPTH(4), .SETTLE_CYCLES(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_s     (cmd_s),
        .cmd_m     (cmd_m),
        .cmd_cn    (cmd_cn),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_s     (alu_s),
        .alu_m     (alu_m),
        .alu_cn    (alu_cn),
        .alu_f     (alu_f),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_f     (res_f)
`ifdef ALU_OP_COUNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    // Active-high 74181: full logic mode, arithmetic only for the selects used here.
    function automatic logic [3:0] alu_model(input logic [3:0] a, input logic [3:0] b,
                                             input logic [3:0] s, input logic m, input logic cn);
        logic [4:0] sum;
        logic [4:0] c;
        c   = {4'b0, ~cn};
        sum = '0;
        if (m) begin
            case (s)
                4'd0:  sum = {1'b0, ~a};
                4'd1:  sum = {1'b0, ~(a | b)};
                4'd2:  sum = {1'b0, ~a & b};
                4'd3:  sum = 5'd0;
                4'd4:  sum = {1'b0, ~(a & b)};
                4'd5:  sum = {1'b0, ~b};
                4'd6:  sum = {1'b0, a ^ b};
                4'd7:  sum = {1'b0, a & ~b};
                4'd8:  sum = {1'b0, ~a | b};
                4'd9:  sum = {1'b0, ~(a ^ b)};
                4'd10: sum = {1'b0, b};
                4'd11: sum = {1'b0, a & b};
                4'd12: sum = 5'h0f;
                4'd13: sum = {1'b0, a | ~b};
                4'd14: sum = {1'b0, a | b};
                default: sum = {1'b0, a};
            endcase
        end else begin
            case (s)
                4'd0:    sum = {1'b0, a} + c;
                4'd1:    sum = {1'b0, a | b} + c;
                4'd9:    sum = {1'b0, a} + {1'b0, b} + c;
                default: sum = 5'd0;
            endcase
        end
        return sum[3:0];
    endfunction

    assign alu_f = alu_model(alu_a, alu_b, alu_s, alu_m, alu_cn);

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- checking and drivers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_a  = v.a;
        cmd_b  = v.b;
        cmd_s  = v.s;
        cmd_m  = v.m;
        cmd_cn = v.cn;
    endtask

    task automatic send(input vec_t v);
        int n;
        drive_cmd(v);
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 200) begin
            tick();
            n++;
        end
        check("send_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        exp_q.push_back(v.exp);
    endtask

    task automatic get_result(input string tag);
        int n;
        logic [3:0] e;
        res_ready = 1'b1;
        n = 0;
        while (!res_valid && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {31'b0, res_valid}, 32'd1);
        check({tag, "_qdepth"}, {31'b0, (exp_q.size() == 0)}, 32'd0);
        if (res_valid && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(tag, {28'b0, res_f}, {28'b0, e});
        end
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int accepted;
        int idx;
        n_checks  = 0;
        n_errors  = 0;
        //            a      b      s      m     cn    exp
        vecs[0] = '{4'd10, 4'd0,  4'd0,  1'b1, 1'b1, 4'd5};   // NOT A
        vecs[1] = '{4'd5,  4'd10, 4'd1,  1'b0, 1'b1, 4'd15};  // A OR B, no carry
        vecs[2] = '{4'd3,  4'd6,  4'd6,  1'b1, 1'b1, 4'd5};   // A XOR B
        vecs[3] = '{4'd12, 4'd10, 4'd11, 1'b1, 1'b1, 4'd8};   // A AND B
        vecs[4] = '{4'd7,  4'd9,  4'd9,  1'b0, 1'b0, 4'd1};   // 7+9+1, wraps
        vecs[5] = '{4'd9,  4'd4,  4'd14, 1'b1, 1'b1, 4'd13};  // A OR B logic
        vecs[6] = '{4'd6,  4'd3,  4'd9,  1'b0, 1'b1, 4'd9};   // 6+3

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        drive_cmd(vecs[0]);
        repeat (3) tick();
        check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("rst_res_valid", {31'b0, res_valid}, 32'd0);
        check("rst_res_f", {28'b0, res_f}, 32'd0);
        check("rst_alu", {18'b0, alu_a, alu_b, alu_s, alu_m, alu_cn}, 32'd0);
`ifdef ALU_OP_COUNT_EN
        check("rst_op_count", {24'b0, op_count}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Basic NOT with exact latency: accept at edge k, drive at k+1, valid at k+2.
        res_ready = 1'b1;
        drive_cmd(vecs[0]);
        cmd_valid = 1'b1;
        check("t1_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        tick();
        cmd_valid = 1'b0;
        check("t1_k_valid", {31'b0, res_valid}, 32'd0);
        tick();
        check("t1_k1_alu", {18'b0, alu_a, alu_b, alu_s, alu_m, alu_cn}, {18'b0, 4'd10, 4'd0, 4'd0, 1'b1, 1'b1});
        check("t1_k1_valid", {31'b0, res_valid}, 32'd0);
        tick();
        check("t1_k2_valid", {31'b0, res_valid}, 32'd1);
        check("t1_k2_res_f", {28'b0, res_f}, 32'd5);
        tick();
        check("t1_after_hs", {31'b0, res_valid}, 32'd0);

        // Basic OR
        send(vecs[1]);
        get_result("t2_or");

        // FIFO fill under backpressure: DEPTH queued + 1 in flight
        res_ready = 1'b0;
        accepted  = 0;
        idx       = 1;
        for (int c = 0; c < 6; c++) begin
            drive_cmd(vecs[idx]);
            cmd_valid = 1'b1;
            if (cmd_ready) begin
                exp_q.push_back(vecs[idx].exp);
                accepted++;
                idx++;
            end
            tick();
        end
        check("t3_accepted", accepted, 32'd5);
        check("t3_full_ready", {31'b0, cmd_ready}, 32'd0);
        fork
            begin
                for (int r = 0; r < 6; r++) get_result("t3_order");
            end
            begin
                int n;
                n = 0;
                while (!cmd_ready && n < 200) begin
                    tick();
                    n++;
                end
                check("t3_sixth_ready", {31'b0, cmd_ready}, 32'd1);
                tick();
                cmd_valid = 1'b0;
                exp_q.push_back(vecs[6].exp);
            end
        join
        check("t3_queue_empty", exp_q.size(), 32'd0);

        // Backpressure: hold in HOLD for 10 cycles
        res_ready = 1'b0;
        send(vecs[2]);
        while (!res_valid) tick();
        for (int c = 0; c < 10; c++) begin
            check("t4_hold", {17'b0, res_valid, res_f, alu_a, alu_b, alu_s, alu_m, alu_cn},
                  {17'b0, 1'b1, 4'd5, 4'd3, 4'd6, 4'd6, 1'b1, 1'b1});
            tick();
        end
        get_result("t4_bp");
        for (int c = 0; c < 3; c++) begin
            check("t4_no_dup", {31'b0, res_valid}, 32'd0);
            tick();
        end

        // Async reset mid-DRIVE with 3 queued
        res_ready = 1'b0;
        send(vecs[1]);
        while (!res_valid) tick();
        for (int v = 3; v < 7; v++) send(vecs[v]);
        check("t5_full", {31'b0, cmd_ready}, 32'd0);
        check("t5_head", {28'b0, res_f}, {28'b0, exp_q.pop_front()});
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("t5_drive_alu_a", {28'b0, alu_a}, 32'd12);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'b0, res_valid}, 32'd0);
        check("t5_rst_ready", {31'b0, cmd_ready}, 32'd1);
        check("t5_rst_alu", {18'b0, alu_a, alu_b, alu_s, alu_m, alu_cn}, 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        res_ready = 1'b1;
        tick();
        for (int c = 0; c < 8; c++) begin
            check("t5_no_stale", {31'b0, res_valid}, 32'd0);
            tick();
        end
        send(vecs[0]);
        get_result("t5_post");

`ifdef ALU_OP_COUNT_EN
        send(vecs[5]);
        get_result("t6_a");
        send(vecs[6]);
        get_result("t6_b");
        check("t6_op_count3", {24'b0, op_count}, 32'd3);
        for (int i = 0; i < 257; i++) begin
            send(vecs[i % 7]);
            get_result("t6_sat_res");
        end
        check("t6_op_count_sat", {24'b0, op_count}, 32'd255);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard stop so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Upstream issue stage for the 4-bit 74181-style ALU.
- Accepts ALU commands (operands plus S/M/Cn) over a valid/ready handshake and queues them in a small FIFO.
- Drives one command at a time onto the ALU inputs and holds them for a fixed settle time, then samples F.
- Returns each result in order over a second valid/ready handshake.

Parameters:
- DEPTH, 4, command FIFO entries (power of two, >=2).
- SETTLE_CYCLES, 1, clock cycles the ALU inputs are held before F is sampled (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  FIFO can accept a command.
- cmd_a  input  4  operand A.
- cmd_b  input  4  operand B.
- cmd_s  input  4  function select S.
- cmd_m  input  1  mode M.
- cmd_cn  input  1  carry Cn.
- alu_a  output  4  to ALU A.
- alu_b  output  4  to ALU B.
- alu_s  output  4  to ALU S.
- alu_m  output  1  to ALU M.
- alu_cn  output  1  to ALU Cn.
- alu_f  input  4  from ALU F.
- res_valid  output  1  result present.
- res_ready  input  1  consumer accepts result.
- res_f  output  4  captured F.

Behaviour:
- Reset (async, rst_n low):
  - FIFO count=0, so cmd_ready=1 and res_valid=0.
  - res_f=0; alu_a/alu_b/alu_s=0; alu_m=0; alu_cn=0.
  - Settle counter=0; state=IDLE.
- Push:
  - Occurs on a rising edge when cmd_valid && cmd_ready.
  - cmd_ready = (count < DEPTH), computed from the current count only. A same-cycle pop does not free a slot for a same-cycle push.
- FIFO:
  - Circular, read/write pointers wrap modulo DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Pop from an empty FIFO never occurs.
- FSM states: IDLE, DRIVE, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head into the alu_* registers, load counter=SETTLE_CYCLES, go to DRIVE. Otherwise stay in IDLE; alu_* keep their last values.
  - DRIVE: decrement the counter each edge. On the edge where the counter goes from 1 to 0, register alu_f into res_f, set res_valid=1, go to HOLD.
  - HOLD: res_valid=1; res_f and alu_* are held stable. On an edge with res_ready=1:
    - if the FIFO is non-empty, pop the next command into alu_*, reload the counter, go to DRIVE, clear res_valid;
    - otherwise clear res_valid and go to IDLE.
- Latency: command accepted at edge k into an empty, idle block -> alu_* driven after edge k+1 -> res_valid high after edge k+1+SETTLE_CYCLES.
- Throughput: one result per SETTLE_CYCLES+1 cycles with res_ready tied high.
- Capacity: at most DEPTH queued + 1 in flight.
- Ordering: results strictly in command order; none dropped or duplicated.
- Backpressure: res_ready low in HOLD stalls indefinitely; pushes continue until the FIFO is full.
- Reset mid-operation: the in-flight command and all queued commands are discarded; no res_valid is issued for them.

Optional Feature:
- Macro: ALU_OP_COUNT_EN.
- Defined:
  - Adds output op_count [7:0].
  - Increments on each completed result handshake (res_valid && res_ready), saturating at 255.
  - Reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Basic NOT, SETTLE_CYCLES=1: push A=10, S=0, M=1, Cn=1 with res_ready=1 -> res_valid high 2 cycles after accept, res_f=4'b0101.
- Basic OR: push A=5, B=10, S=1, M=0, Cn=1 -> res_f=4'b1111.
- FIFO fill: res_ready=0, offer 6 commands back-to-back -> exactly 5 accepted, cmd_ready=0 afterwards. Then res_ready=1 -> 5 results in push order, and the 6th is accepted once a slot frees.
- Backpressure: hold res_ready=0 for 10 cycles in HOLD -> res_f and alu_* unchanged throughout; one handshake then yields exactly one result.
- Async reset: assert rst_n low mid-DRIVE with 3 queued -> immediately res_valid=0, cmd_ready=1, alu_*=0. After release, no stale results appear.
- ALU_OP_COUNT_EN: complete 3 handshakes -> op_count=3. Force 260 completions -> op_count=255.
